// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle RV32I controller (master) and its datapath (slave).
// The illegal_instr line exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_controller_if #(
    parameter int ALUCTRL_W = 3
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_write;
    logic                 ir_write;
    logic [1:0]           result_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [1:0]           imm_src;
    logic                 reg_write;
`ifdef ILLEGAL_TRAP_EN
    logic                 illegal_instr;
`endif

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
        output alu_src_a, alu_src_b, alu_control, imm_src, reg_write
`ifdef ILLEGAL_TRAP_EN
        , output illegal_instr
`endif
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
        input  alu_src_a, alu_src_b, alu_control, imm_src, reg_write
`ifdef ILLEGAL_TRAP_EN
        , input illegal_instr
`endif
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM with ALU and immediate decoders and a mem_ready handshake.
// Define ILLEGAL_TRAP_EN to route unknown opcodes to a sticky TRAP state driving illegal_instr.
module multicycle_controller #(
    parameter int STATE_W   = 4,
    parameter int ALUCTRL_W = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    multicycle_controller_if.master ctrl_if
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b011);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b101);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECR    = STATE_W'(6),
        EXECI    = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9),
        JAL      = STATE_W'(10)
`ifdef ILLEGAL_TRAP_EN
        , TRAP   = STATE_W'(11)
`endif
    } state_e;

    state_e state_q, state_d, out_state;

    logic [ALUCTRL_W-1:0] funct_alu;
    logic                 pc_update;
    logic                 pc_write_d, adr_src_d, mem_write_d, ir_write_d, reg_write_d;
    logic [1:0]           result_src_d, alu_src_a_d, alu_src_b_d, imm_src_d;
    logic [ALUCTRL_W-1:0] alu_control_d;
    logic                 illegal_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        funct_alu = ALU_ADD;
        case (ctrl_if.funct3)
            3'b000:  funct_alu = (ctrl_if.op[5] & ctrl_if.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = ctrl_if.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (ctrl_if.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BR:        state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR:   state_d = (ctrl_if.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = ctrl_if.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = ctrl_if.mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     state_d = TRAP;
`endif
            default:  state_d = FETCH;
        endcase
    end

    // While reset is held the selects decode as FETCH and every enable is suppressed,
    // so an instruction interrupted mid-flight (e.g. a store) writes nothing.
    always_comb begin
        out_state     = reset_i ? FETCH : state_q;
        pc_update     = 1'b0;
        adr_src_d     = 1'b0;
        mem_write_d   = 1'b0;
        ir_write_d    = 1'b0;
        reg_write_d   = 1'b0;
        result_src_d  = 2'b00;
        alu_src_a_d   = 2'b00;
        alu_src_b_d   = 2'b00;
        alu_control_d = ALU_ADD;
        illegal_d     = 1'b0;
        case (out_state)
            FETCH: begin
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
                ir_write_d   = ctrl_if.mem_ready;
                pc_update    = ctrl_if.mem_ready;
            end
            DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
            end
            MEMADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
            end
            MEMREAD:  adr_src_d = 1'b1;
            MEMWB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            MEMWRITE: begin
                adr_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            EXECR: begin
                alu_src_a_d   = 2'b10;
                alu_control_d = funct_alu;
            end
            EXECI: begin
                alu_src_a_d   = 2'b10;
                alu_src_b_d   = 2'b01;
                alu_control_d = funct_alu;
            end
            ALUWB:    reg_write_d = 1'b1;
            BRANCH: begin
                alu_src_a_d   = 2'b10;
                alu_control_d = ALU_SUB;
            end
            JAL: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                pc_update   = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP:     illegal_d = 1'b1;
`endif
            default: begin
                pc_update = 1'b0;
            end
        endcase

        pc_write_d = pc_update |
                     ((out_state == BRANCH) & (ctrl_if.zero ^ ctrl_if.funct3[0]));

        if (reset_i) begin
            pc_write_d  = 1'b0;
            ir_write_d  = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
        end
    end

    always_comb begin
        case (ctrl_if.op)
            OP_SW:   imm_src_d = 2'b01;
            OP_BR:   imm_src_d = 2'b10;
            OP_JAL:  imm_src_d = 2'b11;
            default: imm_src_d = 2'b00;
        endcase
    end

    assign ctrl_if.pc_write    = pc_write_d;
    assign ctrl_if.adr_src     = adr_src_d;
    assign ctrl_if.mem_write   = mem_write_d;
    assign ctrl_if.ir_write    = ir_write_d;
    assign ctrl_if.result_src  = result_src_d;
    assign ctrl_if.alu_src_a   = alu_src_a_d;
    assign ctrl_if.alu_src_b   = alu_src_b_d;
    assign ctrl_if.alu_control = alu_control_d;
    assign ctrl_if.imm_src     = imm_src_d;
    assign ctrl_if.reg_write   = reg_write_d;
`ifdef ILLEGAL_TRAP_EN
    assign ctrl_if.illegal_instr = illegal_d;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle directed vectors push expected controls,
// a negedge monitor pops and compares them against the interface outputs and the state register.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    typedef struct {
        string      name;
        int         st;
        logic [17:0] ctl;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t expQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    multicycle_controller_if #(.ALUCTRL_W(3)) bus ();

    multicycle_controller #(.STATE_W(4), .ALUCTRL_W(3)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .ctrl_if (bus)
    );

    always #5 clk = ~clk;

    // One call covers one clock cycle: drive inputs just after the edge and queue what must appear.
    task automatic applyStimulus(input string name, input logic rst, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7, input logic z, input logic rdy,
                                 input int st, input logic pcW, input logic adr, input logic memW,
                                 input logic irW, input logic [1:0] res, input logic [1:0] srcA,
                                 input logic [1:0] srcB, input logic [2:0] alu, input logic [1:0] imm,
                                 input logic regW, input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.op        = op;
        bus.funct3    = f3;
        bus.funct7b5  = f7;
        bus.zero      = z;
        bus.mem_ready = rdy;
        e.name = name;
        e.st   = st;
        e.ctl  = {pcW, adr, memW, irW, res, srcA, srcB, alu, imm, regW, ill};
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [17:0] got;
        logic        gotIll;
        int          gotSt;
`ifdef ILLEGAL_TRAP_EN
        gotIll = bus.illegal_instr;
`else
        gotIll = 1'b0;
`endif
        got = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
               bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.imm_src, bus.reg_write, gotIll};
        gotSt = int'(dut.state_q);
        testsRun++;
        if (got !== e.ctl || gotSt != e.st) begin
            testsFailed++;
            $display("[TB] FAIL %s: got ctl=%b state=%0d, want ctl=%b state=%0d",
                     e.name, got, gotSt, e.ctl, e.st);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin : stimulus
        reset         = 1'b1;
        bus.op        = LW;
        bus.funct3    = 3'b000;
        bus.funct7b5  = 1'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);

        //             name        rst op  f3      f7 z  rdy st pcW adr mW irW res    srcA   srcB   alu     imm    rW ill
        applyStimulus("rst_hold",  1, LW, 3'b000, 0, 0, 1, 0,  0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);

        applyStimulus("lw_F",      0, LW, 3'b010, 0, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        applyStimulus("lw_D",      0, LW, 3'b010, 0, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
        applyStimulus("lw_MA",     0, LW, 3'b010, 0, 0, 1, 2,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
        applyStimulus("lw_MR",     0, LW, 3'b010, 0, 0, 1, 3,  0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
        applyStimulus("lw_WB",     0, LW, 3'b010, 0, 0, 1, 4,  0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);

        applyStimulus("sw_F",      0, SW, 3'b010, 0, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0);
        applyStimulus("sw_D",      0, SW, 3'b010, 0, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 0, 0);
        applyStimulus("sw_MA",     0, SW, 3'b010, 0, 0, 1, 2,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0);
        applyStimulus("sw_MW0",    0, SW, 3'b010, 0, 0, 0, 5,  0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
        applyStimulus("sw_MW1",    0, SW, 3'b010, 0, 0, 0, 5,  0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
        applyStimulus("sw_MW2",    0, SW, 3'b010, 0, 0, 1, 5,  0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);

        applyStimulus("sub_F",     0, RT, 3'b000, 1, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        applyStimulus("sub_D",     0, RT, 3'b000, 1, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
        applyStimulus("sub_EX",    0, RT, 3'b000, 1, 0, 1, 6,  0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0);
        applyStimulus("sub_WB",    0, RT, 3'b000, 1, 0, 1, 8,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);

        applyStimulus("addi_F",    0, IT, 3'b000, 1, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        applyStimulus("addi_D",    0, IT, 3'b000, 1, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
        applyStimulus("addi_EX",   0, IT, 3'b000, 1, 0, 1, 7,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
        applyStimulus("addi_WB",   0, IT, 3'b000, 1, 0, 1, 8,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);

        applyStimulus("slti_F",    0, IT, 3'b010, 0, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        applyStimulus("slti_D",    0, IT, 3'b010, 0, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
        applyStimulus("slti_EX",   0, IT, 3'b010, 0, 0, 1, 7,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 2'b00, 0, 0);
        applyStimulus("slti_WB",   0, IT, 3'b010, 0, 0, 1, 8,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);

        applyStimulus("or_F",      0, RT, 3'b110, 0, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        applyStimulus("or_D",      0, RT, 3'b110, 0, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
        applyStimulus("or_EX",     0, RT, 3'b110, 0, 0, 1, 6,  0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 0, 0);
        applyStimulus("or_WB",     0, RT, 3'b110, 0, 0, 1, 8,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);

        applyStimulus("beq_F",     0, BR, 3'b000, 0, 1, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0);
        applyStimulus("beq_D",     0, BR, 3'b000, 0, 1, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 0);
        applyStimulus("beq_BR",    0, BR, 3'b000, 0, 1, 1, 9,  1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0);

        applyStimulus("bne_F",     0, BR, 3'b001, 0, 1, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0);
        applyStimulus("bne_D",     0, BR, 3'b001, 0, 1, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 0);
        applyStimulus("bne_BR",    0, BR, 3'b001, 0, 1, 1, 9,  0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0);

        applyStimulus("jal_F",     0, JL, 3'b000, 0, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11, 0, 0);
        applyStimulus("jal_D",     0, JL, 3'b000, 0, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11, 0, 0);
        applyStimulus("jal_J",     0, JL, 3'b000, 0, 0, 1, 10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0);
        applyStimulus("jal_WB",    0, JL, 3'b000, 0, 0, 1, 8,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 0);

        for (int i = 0; i < 3; i++)
            applyStimulus("fwait",  0, RT, 3'b111, 0, 0, 0, 0,  0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        applyStimulus("fwait_go",  0, RT, 3'b111, 0, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        applyStimulus("and_D",     0, RT, 3'b111, 0, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
        applyStimulus("and_EX",    0, RT, 3'b111, 0, 0, 1, 6,  0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 0, 0);
        applyStimulus("and_WB",    0, RT, 3'b111, 0, 0, 1, 8,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);

        applyStimulus("rsw_F",     0, SW, 3'b010, 0, 0, 1, 0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0);
        applyStimulus("rsw_D",     0, SW, 3'b010, 0, 0, 1, 1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 0, 0);
        applyStimulus("rsw_MA",    0, SW, 3'b010, 0, 0, 1, 2,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0);
        applyStimulus("rsw_MW",    0, SW, 3'b010, 0, 0, 0, 5,  0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
        applyStimulus("rsw_RST",   1, SW, 3'b010, 0, 0, 0, 5,  0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0);
        applyStimulus("rsw_after", 0, SW, 3'b010, 0, 0, 0, 0,  0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0);

        applyStimulus("bad_F",     0, BAD, 3'b000, 0, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        applyStimulus("bad_D",     0, BAD, 3'b000, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        applyStimulus("trap0",     0, BAD, 3'b000, 0, 0, 1, 11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1);
        applyStimulus("trap1",     0, BAD, 3'b000, 0, 1, 1, 11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1);
        applyStimulus("trap_rst",  1, BAD, 3'b000, 0, 0, 1, 11, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
`endif
        applyStimulus("bad_next",  0, BAD, 3'b000, 0, 0, 1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d expected entries left, want 0", expQ.size());
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
